// File: rtl/mu0_control.sv
// mu0_control: fetch/execute control FSM for the 12-bit-address MU0 datapath
// Ports: Clk, Reset (sync, active-high), [Step], F (opcode IR[15:12]), N/Z (Acc flags)
//        -> Addr_sel, X_sel, Y_sel, ALU_fs, Acc_En, PC_En, IR_En, MEM_rd, MEM_wr, Halted
// Optional: MU0_SINGLE_STEP_EN adds Step; FETCH then waits for Step==1 before fetching.
module mu0_control (
  input  logic       Clk,
  input  logic       Reset,
`ifdef MU0_SINGLE_STEP_EN
  input  logic       Step,
`endif
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  output logic       Addr_sel,
  output logic       X_sel,
  output logic       Y_sel,
  output logic [1:0] ALU_fs,
  output logic       Acc_En,
  output logic       PC_En,
  output logic       IR_En,
  output logic       MEM_rd,
  output logic       MEM_wr,
  output logic       Halted
);
  typedef enum logic [1:0] {FETCH = 2'b00, EXECUTE = 2'b01, HALT = 2'b10, ILLEGAL = 2'b11} state_t;
  state_t state_q, state_d;
  logic go, jmp;
`ifdef MU0_SINGLE_STEP_EN
  assign go = Step;
`else
  assign go = 1'b1;
`endif
  // JGE/JNE fall through as a NOP when their flag condition fails
  assign jmp = (F == 4'd4) | (F == 4'd5 & ~N) | (F == 4'd6 & ~Z);
  always_comb begin
    Addr_sel = 1'b0;
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    ALU_fs   = 2'b00;
    Acc_En   = 1'b0;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    MEM_rd   = 1'b0;
    MEM_wr   = 1'b0;
    Halted   = 1'b0;
    state_d  = FETCH;
    case (state_q)
      FETCH: begin
        MEM_rd  = go;
        IR_En   = go;
        X_sel   = go;
        ALU_fs  = go ? 2'b10 : 2'b00;
        PC_En   = go;
        state_d = go ? EXECUTE : FETCH;
      end
      EXECUTE: begin
        case (F)
          4'd0: begin
            Addr_sel = 1'b1;
            MEM_rd   = 1'b1;
            Acc_En   = 1'b1;
          end
          4'd1: begin
            Addr_sel = 1'b1;
            MEM_wr   = 1'b1;
          end
          4'd2, 4'd3: begin
            Addr_sel = 1'b1;
            MEM_rd   = 1'b1;
            ALU_fs   = F[0] ? 2'b11 : 2'b01;
            Acc_En   = 1'b1;
          end
          4'd4, 4'd5, 4'd6: begin
            Y_sel = jmp;
            PC_En = jmp;
          end
          4'd7: state_d = HALT;
          default: ;
        endcase
      end
      HALT: begin
        Halted  = 1'b1;
        state_d = HALT;
      end
      default: state_d = FETCH;
    endcase
    // Reset overrides everything so an aborted instruction commits nothing
    if (Reset) begin
      Addr_sel = 1'b0;
      X_sel    = 1'b0;
      Y_sel    = 1'b0;
      ALU_fs   = 2'b00;
      Acc_En   = 1'b0;
      PC_En    = 1'b0;
      IR_En    = 1'b0;
      MEM_rd   = 1'b0;
      MEM_wr   = 1'b0;
      Halted   = 1'b0;
      state_d  = FETCH;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= FETCH;
    else state_q <= state_d;
  end
endmodule
